// File: rtl/controller.sv
// rtl/controller.sv - top-level sequencing FSM of the DSP accelerator chiplet
// Optional watchdog on the engine wait states: define CTRL_WATCHDOG_EN.
module controller #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic ready_for_processing,
  input  logic fir_done,
  input  logic fft_done,
  input  logic config_mode,
  output logic start_fir,
  output logic start_fft,
  output logic start_dma_out,
`ifdef CTRL_WATCHDOG_EN
  output logic timeout_err,
`endif
  output logic processing_active
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_FIR = 3'd1;
  localparam logic [2:0] WAIT_FIR  = 3'd2;
  localparam logic [2:0] START_FFT = 3'd3;
  localparam logic [2:0] WAIT_FFT  = 3'd4;
  localparam logic [2:0] DMA_OUT   = 3'd5;

  logic [2:0] current_state;
  logic [2:0] next_state;
  logic       timeout_hit;

`ifdef CTRL_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        in_wait;

  assign in_wait     = (current_state == WAIT_FIR) || (current_state == WAIT_FFT);
  assign timeout_hit = in_wait && (wait_cnt == TIMEOUT_LAST);

  // Every WAIT entry comes from its START state, so clearing there clears on entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 16'd0;
    end else if ((current_state == START_FIR) || (current_state == START_FFT)) begin
      wait_cnt <= 16'd0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (in_wait && (next_state == IDLE)) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    next_state = IDLE;
    case (current_state)
      IDLE: begin
        if (ready_for_processing) begin
          next_state = config_mode ? START_FFT : START_FIR;
        end
      end
      START_FIR: next_state = WAIT_FIR;
      START_FFT: next_state = WAIT_FFT;
      // A matching done on the timeout cycle still wins.
      WAIT_FIR: begin
        if (fir_done)         next_state = DMA_OUT;
        else if (timeout_hit) next_state = IDLE;
        else                  next_state = WAIT_FIR;
      end
      WAIT_FFT: begin
        if (fft_done)         next_state = DMA_OUT;
        else if (timeout_hit) next_state = IDLE;
        else                  next_state = WAIT_FFT;
      end
      DMA_OUT: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      current_state <= IDLE;
    end else begin
      current_state <= next_state;
    end
  end

  assign start_fir         = (current_state == START_FIR);
  assign start_fft         = (current_state == START_FFT);
  assign start_dma_out     = (current_state == DMA_OUT);
  assign processing_active = (current_state != IDLE);

endmodule

// File: tb/tb_controller.sv
// tb/tb_controller.sv - self-checking bench for controller (job-level model plus directed vectors)
// Watchdog scenario runs only when CTRL_WATCHDOG_EN is defined.
module tb_controller;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready_for_processing = 1'b0;
  logic fir_done = 1'b0;
  logic fft_done = 1'b0;
  logic config_mode = 1'b0;
  logic start_fir, start_fft, start_dma_out, processing_active;
`ifdef CTRL_WATCHDOG_EN
  logic timeout_err;
`endif

  int tests = 0;
  int fails = 0;

  controller #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ready_for_processing (ready_for_processing),
    .fir_done             (fir_done),
    .fft_done             (fft_done),
    .config_mode          (config_mode),
    .start_fir            (start_fir),
    .start_fft            (start_fft),
    .start_dma_out        (start_dma_out),
`ifdef CTRL_WATCHDOG_EN
    .timeout_err          (timeout_err),
`endif
    .processing_active    (processing_active)
  );

  always #5 clk = ~clk;

  // Job-level model: which phase of a job we are in, which engine, and how long we have waited.
  typedef enum int {PH_IDLE, PH_LAUNCH, PH_WAIT, PH_DMA} phase_t;
  phase_t m_phase = PH_IDLE;
  bit     m_fft = 1'b0;
  int     m_waited = 0;
  bit     m_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= PH_IDLE; m_fft <= 1'b0; m_waited <= 0; m_err <= 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE:   if (ready_for_processing) begin m_phase <= PH_LAUNCH; m_fft <= config_mode; end
        PH_LAUNCH: begin m_phase <= PH_WAIT; m_waited <= 0; end
        PH_WAIT: begin
          if (m_fft ? fft_done : fir_done) m_phase <= PH_DMA;
          else begin
            m_waited <= m_waited + 1;
`ifdef CTRL_WATCHDOG_EN
            if (m_waited + 1 == TO) begin m_phase <= PH_IDLE; m_err <= 1'b1; end
`endif
          end
        end
        default:   m_phase <= PH_IDLE;
      endcase
    end
  end

  function automatic logic [6:0] model_view();
    int code;
    case (m_phase)
      PH_IDLE:   code = 0;
      PH_LAUNCH: code = m_fft ? 3 : 1;
      PH_WAIT:   code = m_fft ? 4 : 2;
      default:   code = 5;
    endcase
    return {3'(code), m_phase == PH_LAUNCH && !m_fft, m_phase == PH_LAUNCH && m_fft,
            m_phase == PH_DMA, m_phase != PH_IDLE};
  endfunction

  always @(negedge clk) begin
    logic [6:0] act, exp;
    act = {dut.current_state, start_fir, start_fft, start_dma_out, processing_active};
    exp = model_view();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle_model t=%0t {state,fir,fft,dma,act} actual=%b required=%b", $time, act, exp);
    end
`ifdef CTRL_WATCHDOG_EN
    tests++;
    if (timeout_err !== m_err) begin
      fails++;
      $display("FAIL timeout_err_model t=%0t actual=%b required=%b", $time, timeout_err, m_err);
    end
`endif
  end

  task automatic check(input string name, input int actual, input int required);
    tests++;
    if (actual != required) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Advance one edge; inputs are driven and literals sampled 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string name);
    check({name, "_state"}, dut.current_state, 0);
    check({name, "_outs"}, {start_fir, start_fft, start_dma_out, processing_active}, 0);
  endtask

  initial begin
    int pulses;
    int guard;
    // Reset held two cycles
    step();
    check_idle("during_reset");
    step();
    reset = 1'b0;
    step();
    check_idle("after_reset");

    // FIR job
    config_mode = 1'b0; ready_for_processing = 1'b1;
    step();
    check("fir_launch_state", dut.current_state, 1);
    check("fir_launch_pulse", start_fir, 1);
    step();
    ready_for_processing = 1'b0;
    check("fir_wait_state", dut.current_state, 2);
    check("fir_pulse_one_cycle", start_fir, 0);
    repeat (9) step();
    check("fir_still_waiting", dut.current_state, 2);
    fir_done = 1'b1;
    step();
    fir_done = 1'b0;
    check("fir_dma_state", dut.current_state, 5);
    check("fir_dma_pulse", start_dma_out, 1);
    step();
    check_idle("fir_back_idle");

    // FFT job; stray fir_done in WAIT_FFT ignored
    config_mode = 1'b1; ready_for_processing = 1'b1;
    step();
    ready_for_processing = 1'b0;
    check("fft_launch_pulse", start_fft, 1);
    check("fft_launch_no_fir", start_fir, 0);
    step();
    check("fft_wait_state", dut.current_state, 4);
    fir_done = 1'b1;
    repeat (3) step();
    fir_done = 1'b0;
    check("fft_ignores_fir_done", dut.current_state, 4);
    repeat (16) step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check("fft_dma_pulse", start_dma_out, 1);
    step();
    check_idle("fft_back_idle");

    // config_mode change mid-job ignored
    config_mode = 1'b0; ready_for_processing = 1'b1;
    step();
    ready_for_processing = 1'b0;
    step();
    config_mode = 1'b1;
    repeat (3) step();
    check("cfg_toggle_still_fir", dut.current_state, 2);
    fir_done = 1'b1; fft_done = 1'b1;
    step();
    fir_done = 1'b0; fft_done = 1'b0;
    check("cfg_toggle_dma", start_dma_out, 1);
    step();

    // Continuous ready with fir_done held: one job every 4 cycles
    config_mode = 1'b0; ready_for_processing = 1'b1; fir_done = 1'b1;
    pulses = 0;
    repeat (12) begin
      step();
      pulses += int'(start_fir);
    end
    check("b2b_fir_pulses", pulses, 3);
    ready_for_processing = 1'b0; fir_done = 1'b0;
    guard = 0;
    while (dut.current_state != 3'd0 && guard < 10) begin step(); guard++; end
    check("b2b_drain_bounded", int'(guard < 10), 1);

    // Asynchronous reset during WAIT_FFT
    config_mode = 1'b1; ready_for_processing = 1'b1;
    step();
    ready_for_processing = 1'b0;
    repeat (3) step();
    check("pre_reset_wait_fft", dut.current_state, 4);
    #1 reset = 1'b1;
    #1;
    check_idle("async_reset_immediate");
    step();
    reset = 1'b0;
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    check_idle("done_after_reset_ignored");

`ifdef CTRL_WATCHDOG_EN
    config_mode = 1'b1; ready_for_processing = 1'b1;
    step();
    ready_for_processing = 1'b0;
    pulses = 0;
    repeat (8) begin
      step();
      pulses += int'(start_dma_out);
    end
    check("wd_still_waiting", dut.current_state, 4);
    step();
    check("wd_back_idle", dut.current_state, 0);
    check("wd_err_set", timeout_err, 1);
    check("wd_no_dma", pulses + int'(start_dma_out), 0);
    repeat (3) step();
    check("wd_err_sticky", timeout_err, 1);
`endif

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Top-level sequencing FSM of the DSP accelerator chiplet.
- Waits for the input buffer to report data ready, then launches either the FIR or the FFT engine according to the configuration bit.
- Waits for that engine's done flag, then launches the output DMA and returns to idle.
- Sits between the input DMA/buffer logic, the FIR/FFT engines and the output DMA.

Parameters:
- TIMEOUT_CYCLES, 1024: watchdog limit, in clk cycles, for the WAIT_FIR and WAIT_FFT states. Used only when CTRL_WATCHDOG_EN is defined. Legal range 2..65535.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- ready_for_processing  input  1  level; input data buffer holds a complete frame
- fir_done  input  1  FIR engine finished (pulse or level, min 1 cycle)
- fft_done  input  1  FFT engine finished (pulse or level, min 1 cycle)
- config_mode  input  1  algorithm select: 0=FIR, 1=FFT
- start_fir  output  1  one-cycle start pulse to the FIR engine
- start_fft  output  1  one-cycle start pulse to the FFT engine
- start_dma_out  output  1  one-cycle start pulse to the output DMA
- processing_active  output  1  high while a job is in flight
- (CTRL_WATCHDOG_EN only) timeout_err  output  1  sticky watchdog error flag

Behaviour:
- One clock domain (clk); asynchronous active-high reset. Reset forces current_state=IDLE and all outputs to 0 immediately, including mid-job.
- The state register is named current_state, 3 bits, so benches can probe it hierarchically.
- State encoding: IDLE=0, START_FIR=1, WAIT_FIR=2, START_FFT=3, WAIT_FFT=4, DMA_OUT=5. Codes 6 and 7 are illegal and recover to IDLE on the next edge.
- Transitions (all on rising clk edge):
  - IDLE: ready_for_processing=1 and config_mode=0 -> START_FIR.
  - IDLE: ready_for_processing=1 and config_mode=1 -> START_FFT.
  - IDLE: otherwise stay.
  - config_mode is sampled only in IDLE; changes during a job are ignored.
  - START_FIR -> WAIT_FIR unconditionally.
  - START_FFT -> WAIT_FFT unconditionally.
  - WAIT_FIR: fir_done=1 -> DMA_OUT, else stay. fft_done is ignored here.
  - WAIT_FFT: fft_done=1 -> DMA_OUT, else stay. fir_done is ignored here.
  - DMA_OUT -> IDLE unconditionally.
- Outputs are Moore, decoded from current_state:
  - start_fir=1 only in START_FIR.
  - start_fft=1 only in START_FFT.
  - start_dma_out=1 only in DMA_OUT.
  - processing_active=1 in every state except IDLE.
- Latency:
  - ready seen in IDLE -> start pulse on the next cycle.
  - done seen -> start_dma_out on the next cycle.
  - Back in IDLE one cycle after start_dma_out.
- ready_for_processing is level-sensitive. If it is still high when IDLE is re-entered, a new job starts one cycle later. At most one job per IDLE visit; no back-to-back pulses without passing through IDLE.
- A done flag arriving in IDLE, START_* or DMA_OUT is ignored. It is not remembered.
- Simultaneous fir_done and fft_done: only the flag matching the current WAIT state has any effect.

Optional Feature:
- Macro CTRL_WATCHDOG_EN.
- When defined:
  - A 16-bit cycle counter clears on entry to WAIT_FIR/WAIT_FFT and increments each cycle spent in the WAIT state.
  - If the counter reaches TIMEOUT_CYCLES without a matching done, the FSM goes to IDLE with no start_dma_out pulse, and timeout_err sets.
  - timeout_err stays set until reset.
  - A done flag on the same cycle as the timeout wins: the FSM goes to DMA_OUT and no error is flagged.
- When undefined: no counter, no timeout_err port, and the WAIT states wait indefinitely.

Test Plan:
- Reset held 2 cycles, then released -> current_state=0 and all four outputs 0, both during and after reset.
- config_mode=0, ready=1 for 2 cycles, fir_done pulsed 10 cycles later -> start_fir high exactly 1 cycle; state sequence 1, 2 (held), 5, 0; start_dma_out high 1 cycle, one cycle after fir_done; processing_active high from START_FIR through DMA_OUT; start_fft never asserts.
- config_mode=1, ready=1, fft_done after 20 cycles -> start_fft 1-cycle pulse; state sequence 3, 4, 5, 0; fir_done pulsed during WAIT_FFT has no effect.
- config_mode toggled 0->1 while in WAIT_FIR -> FSM still completes via fir_done; no FFT start.
- ready held high continuously -> jobs repeat with period (wait cycles + 4); exactly one start pulse per job.
- Reset asserted asynchronously during WAIT_FFT (between edges) -> outputs and current_state go to 0 before the next edge; a later fft_done is ignored. With CTRL_WATCHDOG_EN and TIMEOUT_CYCLES=8, no done -> FSM returns to IDLE after 8 wait cycles, timeout_err=1, no start_dma_out.
